// File: rtl/chan_arbiter_n.sv
// -----------------------------------------------------------------------------
// chan_arbiter_n
//
// Merges per-channel data blocks onto one GTP lane. Channels request a block
// with req; one winner is granted (fixed or round-robin priority) and its
// block (header word + count data words) is streamed onto dout. A per-word
// rd strobe lets a channel hold its word while a trigger K-word is inserted,
// so no data is lost. A winner that drops req mid-block is aborted and the
// abort is flagged with an ABORTK word and counted in err_cnt.
//
// Ports:
//   clk      in   CLK125
//   reset    in   synchronous, active-high
//   data     in   NCH*DW  channel words, channel i on [DW*i +: DW]
//   req      in   NCH     block request per channel
//   enable   in   NCH     channel enable mask (only used when arbitrating)
//   trigger  in   1       insert TRIGK on the next output word
//   ack      out  NCH     one-hot grant, registered
//   rd       out  NCH     word-consumed strobe, combinational
//   dout     out  DW      output word, registered
//   kchar    out  1       K-character flag for dout, registered
//   err_cnt  out  16      aborted-block counter, saturating
// -----------------------------------------------------------------------------
module chan_arbiter_n #(
    parameter int              NCH     = 16,
    parameter int              DW      = 16,
    parameter int              LENBITS = 8,
    parameter int              RR      = 1,
    parameter logic [DW-1:0]   IDLEK   = 16'h50BC,
    parameter logic [DW-1:0]   TRIGK   = 16'h1C1C,
    parameter logic [DW-1:0]   ABORTK  = 16'h3C3C
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*DW-1:0]   data,
    input  logic [NCH-1:0]      req,
    input  logic [NCH-1:0]      enable,
    input  logic                trigger,
    output logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      rd,
    output logic [DW-1:0]       dout,
    output logic                kchar,
    output logic [15:0]         err_cnt
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_HEADER,
        S_DATA,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        win_q, win_d;      // granted channel
    logic [IW-1:0]        ptr_q, ptr_d;      // last granted channel (round-robin)
    logic [LENBITS-1:0]   cnt_q, cnt_d;      // data words still to transfer
    logic [NCH-1:0]       ack_q, ack_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic                 kchar_q, kchar_d;
    logic [15:0]          err_cnt_q, err_cnt_d;

    // Channel words as an array so the winner's word is a plain index.
    logic [DW-1:0] chan_word [NCH];
    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign chan_word[i] = data[DW*i +: DW];
    end

    logic [DW-1:0]      cur_word;
    logic [LENBITS-1:0] hdr_len;
    assign cur_word = chan_word[win_q];
    assign hdr_len  = cur_word[LENBITS-1:0];

    // -------------------------------------------------------------------------
    // Winner selection. The scan starts just after the pointer in round-robin
    // mode and at channel 0 in fixed mode; the first enabled requester wins.
    // -------------------------------------------------------------------------
    logic [NCH-1:0] req_en;
    logic [IW-1:0]  cand;
    logic [IW-1:0]  pick;
    logic           pick_vld;
    int             base;

    always_comb begin
        req_en   = req & enable;
        base     = (RR != 0) ? int'(ptr_q) + 1 : 0;
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand = IW'((base + k) % NCH);
            if (!pick_vld && req_en[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic.
    // -------------------------------------------------------------------------
    logic abort;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        err_cnt_d = err_cnt_q;
        dout_d    = IDLEK;
        kchar_d   = 1'b1;
        rd        = '0;
        abort     = 1'b0;

        // A trigger owns the next output slot. Everything except arbitration
        // in IDLE is frozen for this cycle and rd stays low, so the channel
        // keeps presenting the same word.
        if (trigger) begin
            dout_d  = TRIGK;
            kchar_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d     = S_GRANT;
                    win_d       = pick;
                    ack_d       = '0;
                    ack_d[pick] = 1'b1;
                    if (RR != 0) begin
                        ptr_d = pick;
                    end
                end
            end

            S_GRANT: begin
                if (!trigger) begin
                    if (!req[win_q]) begin
                        abort = 1'b1;
                    end else begin
                        state_d = S_HEADER;
                    end
                end
            end

            S_HEADER: begin
                if (!trigger) begin
                    rd[win_q] = 1'b1;
                    if (!req[win_q]) begin
                        abort = 1'b1;
                    end else begin
                        dout_d  = cur_word;
                        kchar_d = 1'b0;
                        cnt_d   = hdr_len;
                        if (hdr_len == '0) begin
                            // Header-only block: the header is the last word.
                            state_d = S_GAP;
                            ack_d   = '0;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (!trigger) begin
                    rd[win_q] = 1'b1;
                    if (!req[win_q]) begin
                        abort = 1'b1;
                    end else begin
                        dout_d  = cur_word;
                        kchar_d = 1'b0;
                        cnt_d   = cnt_q - LENBITS'(1);
                        if (cnt_q == LENBITS'(1)) begin
                            state_d = S_GAP;
                            ack_d   = '0;
                        end
                    end
                end
            end

            S_GAP: begin
                if (!trigger) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                ack_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_GAP;
            ack_d   = '0;
            dout_d  = ABORTK;
            kchar_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; a mid-block reset drops the grant and
        // returns to IDLE so the block restarts from a fresh grant.
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q   <= S_IDLE;
            win_q     <= '0;
            ptr_q     <= IW'(NCH - 1);
            cnt_q     <= '0;
            ack_q     <= '0;
            dout_q    <= IDLEK;
            kchar_q   <= 1'b1;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
            kchar_q   <= kchar_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ack     = ack_q;
    assign dout    = dout_q;
    assign kchar   = kchar_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_chan_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_chan_arbiter_n
//
// Directed bench for chan_arbiter_n (NCH=16, DW=16, LENBITS=8). Channel i
// presents word (d | i<<12), so the top nibble of dout identifies the channel.
// Inputs change 1 ns after the rising edge; outputs are compared on the
// falling edge. A second instance with fixed priority shares all inputs.
// -----------------------------------------------------------------------------
module tb_chan_arbiter_n;

    localparam int NCH = 16;
    localparam int DW  = 16;
    localparam logic [15:0] IDLEK  = 16'h50BC;
    localparam logic [15:0] TRIGK  = 16'h1C1C;
    localparam logic [15:0] ABORTK = 16'h3C3C;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*DW-1:0] data = '0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    enable = '1;
    logic              trigger = 1'b0;

    logic [NCH-1:0]    ack, rd;
    logic [DW-1:0]     dout;
    logic              kchar;
    logic [15:0]       err_cnt;

    logic [NCH-1:0]    fix_ack, fix_rd;
    logic [DW-1:0]     fix_dout;
    logic              fix_kchar;
    logic [15:0]       fix_err_cnt;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    chan_arbiter_n #(.NCH(NCH), .DW(DW), .LENBITS(8), .RR(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .req     (req),
        .enable  (enable),
        .trigger (trigger),
        .ack     (ack),
        .rd      (rd),
        .dout    (dout),
        .kchar   (kchar),
        .err_cnt (err_cnt)
    );

    chan_arbiter_n #(.NCH(NCH), .DW(DW), .LENBITS(8), .RR(0)) u_fix (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .req     (req),
        .enable  (enable),
        .trigger (trigger),
        .ack     (fix_ack),
        .rd      (fix_rd),
        .dout    (fix_dout),
        .kchar   (fix_kchar),
        .err_cnt (fix_err_cnt)
    );

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        trig;
        logic [15:0] d;
        logic [15:0] ack;
        logic [15:0] rd;
        logic [15:0] dout;
        logic        kchar;
        logic [15:0] err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void row(input logic rst, input logic [15:0] rq, input logic tg,
                                input logic [15:0] d, input logic [15:0] a,
                                input logic [15:0] r, input logic [15:0] o,
                                input logic k, input logic [15:0] e);
        vec_t v;
        v.rst = rst; v.req = rq; v.trig = tg; v.d = d;
        v.ack = a; v.rd = r; v.dout = o; v.kchar = k; v.err = e;
        tbl.push_back(v);
    endfunction

    task automatic drive_data(input logic [15:0] d);
        for (int ch = 0; ch < NCH; ch++) begin
            data[DW*ch +: DW] = d | (16'(ch) << 12);
        end
    endtask

    // Leaves reset asserted so the next rising edge resets the DUT; the
    // following cycle is IDLE with reset values.
    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; req = '0; trigger = 1'b0; enable = '1;
        drive_data(16'h0000);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            reset   = tbl[i].rst;
            req     = tbl[i].req;
            trigger = tbl[i].trig;
            drive_data(tbl[i].d);
            @(negedge clk);
            check($sformatf("%s[%0d] ack", tag, i),   32'(ack),     32'(tbl[i].ack));
            check($sformatf("%s[%0d] rd", tag, i),    32'(rd),      32'(tbl[i].rd));
            check($sformatf("%s[%0d] dout", tag, i),  32'(dout),    32'(tbl[i].dout));
            check($sformatf("%s[%0d] kchar", tag, i), 32'(kchar),   32'(tbl[i].kchar));
            check($sformatf("%s[%0d] err", tag, i),   32'(err_cnt), 32'(tbl[i].err));
        end
        tbl.delete();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Test 1: single block, ch3, len=2 -------------------
        apply_reset();
        //   rst req       tg d         ack       rd        dout      k  err
        row(0, 16'h0008, 0, 16'h0002, 16'h0000, 16'h0000, IDLEK,    1, 0); // IDLE
        row(0, 16'h0008, 0, 16'h0002, 16'h0008, 16'h0000, IDLEK,    1, 0); // GRANT
        row(0, 16'h0008, 0, 16'h0002, 16'h0008, 16'h0008, IDLEK,    1, 0); // HEADER
        row(0, 16'h0008, 0, 16'h00A1, 16'h0008, 16'h0008, 16'h3002, 0, 0); // DATA
        row(0, 16'h0008, 0, 16'h00A2, 16'h0008, 16'h0008, 16'h30A1, 0, 0); // DATA last
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h30A2, 0, 0); // GAP
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 0); // IDLE
        run_table("t1");

        // ---------------- Test 2: round-robin vs fixed priority --------------
        apply_reset();
        @(posedge clk); #1;
        reset = 1'b0; req = 16'h0009; drive_data(16'h0000);
        @(negedge clk);  // IDLE of block 0
        for (int blk = 0; blk < 4; blk++) begin
            for (int ph = 1; ph < 4; ph++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (ph == 1) begin
                    check($sformatf("t2 rr grant %0d", blk), 32'(ack),
                          (blk % 2 == 0) ? 32'h0001 : 32'h0008);
                    check($sformatf("t2 fix grant %0d", blk), 32'(fix_ack), 32'h0001);
                end
                if (ph == 3) begin
                    check($sformatf("t2 rr gap dout %0d", blk), 32'(dout),
                          (blk % 2 == 0) ? 32'h0000 : 32'h3000);
                    check($sformatf("t2 rr gap ack %0d", blk), 32'(ack), 32'h0000);
                end
            end
            @(posedge clk); #1;  // IDLE of next block
            @(negedge clk);
        end

        // Disabled channel 0: both instances must serve only channel 3.
        apply_reset();
        @(posedge clk); #1;
        reset = 1'b0; enable = 16'hFFFE; req = 16'h0009;
        @(negedge clk);
        for (int blk = 0; blk < 2; blk++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("t2 en rr grant %0d", blk), 32'(ack), 32'h0008);
            check($sformatf("t2 en fix grant %0d", blk), 32'(fix_ack), 32'h0008);
            for (int ph = 0; ph < 3; ph++) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
        end

        // ---------------- Test 3: trigger mid-block, ch1, len=3 --------------
        apply_reset();
        begin
            int nrd;
            nrd = 0;
            row(0, 16'h0002, 0, 16'h0003, 16'h0000, 16'h0000, IDLEK,    1, 0);
            row(0, 16'h0002, 0, 16'h0003, 16'h0002, 16'h0000, IDLEK,    1, 0);
            row(0, 16'h0002, 0, 16'h0003, 16'h0002, 16'h0002, IDLEK,    1, 0);
            row(0, 16'h0002, 0, 16'h00D1, 16'h0002, 16'h0002, 16'h1003, 0, 0);
            row(0, 16'h0002, 1, 16'h00D2, 16'h0002, 16'h0000, 16'h10D1, 0, 0); // trigger
            row(0, 16'h0002, 0, 16'h00D2, 16'h0002, 16'h0002, TRIGK,    1, 0);
            row(0, 16'h0002, 0, 16'h00D3, 16'h0002, 16'h0002, 16'h10D2, 0, 0);
            row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h10D3, 0, 0);
            row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 0);
            fork
                run_table("t3");
                begin
                    for (int c = 0; c < 9; c++) begin
                        @(negedge clk);
                        if (rd[1]) nrd++;
                    end
                end
            join
            check("t3 rd count", 32'(nrd), 32'd4);
        end

        // ---------------- Test 4: abort, ch5, len=10 ------------------------
        apply_reset();
        row(0, 16'h0020, 0, 16'h000A, 16'h0000, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0020, 0, 16'h000A, 16'h0020, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0020, 0, 16'h000A, 16'h0020, 16'h0020, IDLEK,    1, 0);
        row(0, 16'h0000, 0, 16'h0001, 16'h0020, 16'h0020, 16'h500A, 0, 0); // req drops
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, ABORTK,   1, 1);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 1);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 1);
        run_table("t4");

        // ---------------- Test 5: abort + trigger, then saturation -----------
        apply_reset();
        row(0, 16'h0004, 0, 16'h0005, 16'h0000, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0004, 0, 16'h0005, 16'h0004, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0004, 0, 16'h0005, 16'h0004, 16'h0004, IDLEK,    1, 0);
        row(0, 16'h0000, 1, 16'h00E1, 16'h0004, 16'h0000, 16'h2005, 0, 0); // drop + trig
        row(0, 16'h0000, 0, 16'h00E1, 16'h0004, 16'h0004, TRIGK,    1, 0);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, ABORTK,   1, 1);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 1);
        run_table("t5a");

        // Stand-in for 65534 earlier aborts: hold the counter at 16'hFFFE across
        // one idle edge so the register itself holds that value afterwards.
        @(posedge clk); #1;
        force dut.err_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.err_cnt_q;
        @(negedge clk);
        row(0, 16'h0004, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 16'hFFFE);
        row(0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h0000, IDLEK,    1, 16'hFFFE);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, ABORTK,   1, 16'hFFFF);
        row(0, 16'h0004, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 16'hFFFF);
        row(0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h0000, IDLEK,    1, 16'hFFFF);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, ABORTK,   1, 16'hFFFF);
        row(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, IDLEK,    1, 16'hFFFF);
        run_table("t5b");

        // ---------------- Test 6: reset mid-DATA, ch3, len=4 ----------------
        apply_reset();
        row(0, 16'h0008, 0, 16'h0004, 16'h0000, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0008, 0, 16'h0004, 16'h0008, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0008, 0, 16'h0004, 16'h0008, 16'h0008, IDLEK,    1, 0);
        row(0, 16'h0008, 0, 16'h00B0, 16'h0008, 16'h0008, 16'h3004, 0, 0);
        row(1, 16'h0008, 0, 16'h00B1, 16'h0008, 16'h0008, 16'h30B0, 0, 0); // reset
        row(0, 16'h0008, 0, 16'h0004, 16'h0000, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0008, 0, 16'h0004, 16'h0008, 16'h0000, IDLEK,    1, 0);
        row(0, 16'h0008, 0, 16'h0004, 16'h0008, 16'h0008, IDLEK,    1, 0);
        row(0, 16'h0008, 0, 16'h00C0, 16'h0008, 16'h0008, 16'h3004, 0, 0);
        run_table("t6");

        // ---------------- Test 7: maximum length header (255), ch0 ----------
        apply_reset();
        begin
            int  widx;
            int  nrd;
            bit  done;
            widx = 0; nrd = 0; done = 1'b0;
            for (int c = 0; c < 400 && !done; c++) begin
                @(posedge clk); #1;
                reset = 1'b0;
                req   = 16'h0001;
                drive_data((widx == 0) ? 16'h00FF : 16'(16'h0800 + widx));
                @(negedge clk);
                if (rd[0]) begin
                    nrd++;
                    widx++;
                end
                if (nrd > 0 && !ack[0]) begin
                    done = 1'b1;
                    check("t7 rd count", 32'(nrd), 32'd256);
                    check("t7 last word", 32'(dout), 32'h08FF);
                    check("t7 last kchar", 32'(kchar), 32'h0);
                end
            end
            check("t7 block finished in budget", 32'(done), 32'h1);
            req = '0;
            @(posedge clk); #1;
            @(negedge clk);
            check("t7 idle dout", 32'(dout), 32'(IDLEK));
            check("t7 idle kchar", 32'(kchar), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
